// File: rtl/dfe_prl.sv
`default_nettype none
// ============================================================================
//  Module   : dfe_prl
//  Purpose  : PAM-4 decision feedback equalizer with parallel post-cursor
//             taps. Each valid sample has the ISI of the previously decided
//             symbols removed, is sliced to a PAM-4 level in the same cycle,
//             and the corrected sample is registered out with one cycle of
//             latency.
//  Options  : DFE_SATURATE_EN - when defined, the corrected sample is clamped
//             to the signed SIGNAL_RESOLUTION range on output; otherwise it
//             is truncated (wrap-around). Slicing always uses full width.
//  Revision : 1.0 - initial release
// ============================================================================
module dfe_prl #(
  parameter int PULSE_RESPONSE_LENGTH = 3,
  parameter int SIGNAL_RESOLUTION     = 10,
  parameter int SYMBOL_SEPERATION     = 56,
  parameter logic [8*(PULSE_RESPONSE_LENGTH-1)-1:0] TAP_COEFFS = {8'd64, 8'd128}
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SIGNAL_RESOLUTION-1:0] signal_in,
  input  logic                         signal_in_valid,
  output logic [SIGNAL_RESOLUTION-1:0] signal_out,
  output logic                         signal_out_valid
);

  // Number of post-cursor taps (one history entry per tap).
  localparam int NTAP = PULSE_RESPONSE_LENGTH - 1;
  localparam int SR   = SIGNAL_RESOLUTION;

  // Internal arithmetic width: comfortably wider than SR+10 so that a level
  // times an 8-bit coefficient, summed over all taps and subtracted from the
  // input, can never overflow.
  localparam int ACCW = SR + 12 + $clog2(PULSE_RESPONSE_LENGTH);

  // PAM-4 levels and slicer thresholds at internal width.
  localparam logic signed [ACCW-1:0] C_LVL_P3 = ACCW'((3 * SYMBOL_SEPERATION) / 2);
  localparam logic signed [ACCW-1:0] C_LVL_P1 = ACCW'(SYMBOL_SEPERATION / 2);
  localparam logic signed [ACCW-1:0] C_LVL_M1 = ACCW'(-(SYMBOL_SEPERATION / 2));
  localparam logic signed [ACCW-1:0] C_LVL_M3 = ACCW'(-((3 * SYMBOL_SEPERATION) / 2));
  localparam logic signed [ACCW-1:0] C_THR_P  = ACCW'(SYMBOL_SEPERATION);
  localparam logic signed [ACCW-1:0] C_THR_N  = ACCW'(-SYMBOL_SEPERATION);

  // Output range for the clamped narrowing.
  localparam logic signed [ACCW-1:0] C_OUT_MAX = ACCW'((2 ** (SR - 1)) - 1);
  localparam logic signed [ACCW-1:0] C_OUT_MIN = ACCW'(-(2 ** (SR - 1)));

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic signed [ACCW-1:0] hist_q [NTAP];   // hist_q[0] is d1, the newest decision
  logic signed [ACCW-1:0] hist_d [NTAP];
  logic [SR-1:0]          out_q;
  logic [SR-1:0]          out_d;
  logic                   out_valid_q;
  logic                   out_valid_d;

  // --------------------------------------------------------------------------
  // Datapath wires
  // --------------------------------------------------------------------------
  logic signed [ACCW-1:0] term_w [NTAP];   // (d_k * h_k) >>> 8 per tap
  logic signed [ACCW-1:0] isi_w;           // total ISI estimate
  logic signed [ACCW-1:0] in_ext_w;        // sign-extended input sample
  logic signed [ACCW-1:0] c_w;             // corrected sample, full width
  logic signed [ACCW-1:0] dec_w;           // slicer decision
  logic [SR-1:0]          narrow_w;        // corrected sample at output width

  // Per-tap ISI contribution. The coefficient is unsigned Q0.8, so it is
  // zero-extended before the signed multiply; the shift floors toward -inf.
  for (genvar k = 0; k < NTAP; k++) begin : g_tap
    logic signed [ACCW-1:0] coef_w;
    logic signed [ACCW-1:0] prod_w;
    assign coef_w    = {{(ACCW-8){1'b0}}, TAP_COEFFS[8*k +: 8]};
    assign prod_w    = hist_q[k] * coef_w;
    assign term_w[k] = prod_w >>> 8;
  end

  // Sum the ISI contributions of all history taps.
  always_comb begin
    isi_w = '0;
    for (int k = 0; k < NTAP; k++) begin
      isi_w = isi_w + term_w[k];
    end
  end

  assign in_ext_w = {{(ACCW-SR){signal_in[SR-1]}}, signal_in};
  assign c_w      = in_ext_w - isi_w;

  // Four-level slicer on the full-width corrected sample.
  always_comb begin
    if (c_w >= C_THR_P) begin
      dec_w = C_LVL_P3;
    end else if (!c_w[ACCW-1]) begin
      dec_w = C_LVL_P1;
    end else if (c_w >= C_THR_N) begin
      dec_w = C_LVL_M1;
    end else begin
      dec_w = C_LVL_M3;
    end
  end

`ifdef DFE_SATURATE_EN
  // Clamp the corrected sample into the signed output range.
  always_comb begin
    if (c_w > C_OUT_MAX) begin
      narrow_w = {1'b0, {(SR-1){1'b1}}};
    end else if (c_w < C_OUT_MIN) begin
      narrow_w = {1'b1, {(SR-1){1'b0}}};
    end else begin
      narrow_w = c_w[SR-1:0];
    end
  end
`else
  // Keep only the low bits; out-of-range values wrap around.
  always_comb begin
    narrow_w = c_w[SR-1:0];
  end
`endif

  // Next-state: a valid sample shifts the decision history and loads the
  // output; an idle cycle holds everything and only drops the valid flag.
  always_comb begin
    hist_d      = hist_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    if (signal_in_valid) begin
      hist_d[0] = dec_w;
      for (int k = 1; k < NTAP; k++) begin
        hist_d[k] = hist_q[k-1];
      end
      out_d       = narrow_w;
      out_valid_d = 1'b1;
    end
  end

  // State registers; reset clears history so no ISI is subtracted afterwards
  // and discards any sample presented while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      for (int k = 0; k < NTAP; k++) begin
        hist_q[k] <= '0;
      end
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      for (int k = 0; k < NTAP; k++) begin
        hist_q[k] <= hist_d[k];
      end
    end
  end

  assign signal_out       = out_q;
  assign signal_out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_dfe_prl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dfe_prl
//  Purpose  : Self-checking bench for dfe_prl: directed per-cycle vector
//             table followed by a randomized stream against a reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dfe_prl;

  localparam int SR   = 10;
  localparam int S    = 56;
  localparam int NTAP = 2;

`ifdef DFE_SATURATE_EN
  localparam int EXP_SAT = -512;
`else
  localparam int EXP_SAT = 449;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [SR-1:0] signal_in = '0;
  logic          signal_in_valid = 1'b0;
  logic [SR-1:0] signal_out;
  logic          signal_out_valid;

  int n_tests = 0;
  int n_fail  = 0;

  dfe_prl dut (
    .clk              (clk),
    .rst              (rst),
    .signal_in        (signal_in),
    .signal_in_valid  (signal_in_valid),
    .signal_out       (signal_out),
    .signal_out_valid (signal_out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rst;
    int vld;
    int din;
    int exp_vld;
    int exp_out;
    string tag;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int r, input int v, input int d,
                              input int ev, input int eo, input string t);
    vec_t x;
    x.rst = r; x.vld = v; x.din = d; x.exp_vld = ev; x.exp_out = eo; x.tag = t;
    vecs.push_back(x);
  endfunction

  // Drive one cycle on the falling edge, then sample just after the rising edge.
  task automatic cycle(input int r, input int v, input int d);
    @(negedge clk);
    rst             = (r != 0);
    signal_in_valid = (v != 0);
    signal_in       = SR'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int hist_m[$];                 // hist_m[0] = newest decision
  int h_m[NTAP] = '{128, 64};
  int out_m;
  int vld_m;

  function automatic int floor_div256(input int p);
    return (p >= 0) ? (p / 256) : -((-p + 255) / 256);
  endfunction

  function automatic int slice(input int c);
    if (c >= S)       return (3 * S) / 2;
    else if (c >= 0)  return S / 2;
    else if (c >= -S) return -(S / 2);
    else              return -((3 * S) / 2);
  endfunction

  function automatic int narrow(input int c);
`ifdef DFE_SATURATE_EN
    if (c > 511)  return 511;
    if (c < -512) return -512;
    return c;
`else
    int m;
    m = c & 1023;
    return (m >= 512) ? m - 1024 : m;
`endif
  endfunction

  task automatic model_reset();
    hist_m = {};
    for (int k = 0; k < NTAP; k++) hist_m.push_back(0);
    out_m = 0;
    vld_m = 0;
  endtask

  task automatic model_step(input int v, input int x);
    int c;
    if (v != 0) begin
      c = x;
      for (int k = 0; k < NTAP; k++) c -= floor_div256(hist_m[k] * h_m[k]);
      out_m = narrow(c);
      vld_m = 1;
      hist_m.push_front(slice(c));
      void'(hist_m.pop_back());
    end else begin
      vld_m = 0;
    end
  endtask

  initial begin
    // Reset held two cycles with a valid sample that must be dropped.
    add(1, 1, 100, 0, 0,   "rst_hold0");
    add(1, 1, 100, 0, 0,   "rst_hold1");
    add(0, 1, 100, 1, 100, "post_rst_pass");
    // Back-to-back channel stream.
    add(1, 0, 0,   0, 0,   "rst");
    add(0, 1, 84,  1, 84,  "chan0");
    add(0, 1, 14,  1, -28, "chan1");
    add(0, 1, 35,  1, 28,  "chan2");
    // Same stream with idle gaps.
    add(1, 0, 0,   0, 0,   "rst");
    add(0, 1, 84,  1, 84,  "gap_s0");
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 84, "gap_hold0");
    add(0, 1, 14,  1, -28, "gap_s1");
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, -28, "gap_hold1");
    add(0, 1, 35,  1, 28,  "gap_s2");
    add(0, 0, 0,   0, 28,  "gap_hold2");
    // Output narrowing on an out-of-range corrected value.
    add(1, 0, 0,    0, 0,       "rst");
    add(0, 1, 84,   1, 84,      "sat0");
    add(0, 1, 126,  1, 84,      "sat1");
    add(0, 1, -512, 1, EXP_SAT, "sat2");
    // Slicer boundaries at 0 and S.
    add(1, 0, 0,  0, 0,   "rst");
    add(0, 1, 0,  1, 0,   "slc_zero0");
    add(0, 1, 0,  1, -14, "slc_zero1");
    add(1, 0, 0,  0, 0,   "rst");
    add(0, 1, 56, 1, 56,  "slc_s0");
    add(0, 1, 0,  1, -42, "slc_s1");
    // Reset mid-stream drops the presented sample and clears history.
    add(1, 0, 0,  0, 0,   "rst");
    add(0, 1, 84, 1, 84,  "mid0");
    add(0, 1, 14, 1, -28, "mid1");
    add(1, 1, 35, 0, 0,   "mid_rst");
    add(0, 1, 35, 1, 35,  "mid_after");

    foreach (vecs[i]) begin
      cycle(vecs[i].rst, vecs[i].vld, vecs[i].din);
      check({vecs[i].tag, "_vld"}, int'(signal_out_valid), vecs[i].exp_vld);
      check({vecs[i].tag, "_out"}, int'($signed(signal_out)), vecs[i].exp_out);
    end

    // ---------------- randomized stream vs model ----------------
    cycle(1, 0, 0);
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      int r, v, x;
      r = ($urandom_range(0, 99) == 0) ? 1 : 0;
      v = ($urandom_range(0, 9) < 7) ? 1 : 0;
      x = int'($urandom_range(0, 1023)) - 512;
      cycle(r, v, x);
      if (r != 0) model_reset();
      else        model_step(v, x);
      check("rnd_vld", int'(signal_out_valid), vld_m);
      check("rnd_out", int'($signed(signal_out)), out_m);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dfe_prl.md
DFE_PRL -- requirements
Module: dfe_prl

Interface
REQ-001 SHALL have parameter PULSE_RESPONSE_LENGTH, default 3: channel pulse length in symbols (cursor + PULSE_RESPONSE_LENGTH-1 post-cursor taps).
REQ-002 SHALL have parameter SIGNAL_RESOLUTION, default 10: sample width, signed two's complement.
REQ-003 SHALL have parameter SYMBOL_SEPERATION, default 56: PAM-4 level spacing; levels are -3S/2, -S/2, +S/2, +3S/2 (-84, -28, 28, 84 at default).
REQ-004 SHALL have parameter TAP_COEFFS, packed 8*(PULSE_RESPONSE_LENGTH-1) bits, default {8'd64, 8'd128}: unsigned Q0.8 post-cursor taps, h1 in bits [7:0] (0.5), h2 in bits [15:8] (0.25).
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous reset, active-high.
REQ-007 signal_in  input  SIGNAL_RESOLUTION  received, ISI-corrupted sample.
REQ-008 signal_in_valid  input  1  signal_in qualifier.
REQ-009 signal_out  output  SIGNAL_RESOLUTION  ISI-cancelled sample.
REQ-010 signal_out_valid  output  1  signal_out qualifier.

Function
REQ-011 SHALL keep a decision history d1..d(PULSE_RESPONSE_LENGTH-1), d1 being the most recent decided level.
REQ-012 On a cycle with signal_in_valid=1, SHALL compute c = signal_in - sum over k of ((d_k * h_k) >>> 8), each product signed, arithmetic right shift (floor), sum in at least SIGNAL_RESOLUTION+10 bits.
REQ-013 SHALL slice c the same cycle: c>=S -> +3S/2; 0<=c<S -> +S/2; -S<=c<0 -> -S/2; c<-S -> -3S/2.
REQ-014 At the clock edge of a valid cycle, SHALL shift the history (d_k <= d_(k-1)) and load d1 with the slicer decision; decision feedback SHALL apply to the very next valid sample (no decision pipeline bubble).
REQ-015 SHALL register c (narrowed per REQ-023) to signal_out and set signal_out_valid=1 one clock after the input valid cycle; latency exactly 1 cycle.
REQ-016 On a cycle with signal_in_valid=0, SHALL hold history and signal_out unchanged and drive signal_out_valid=0 next cycle.
REQ-017 Valid gaps of any length SHALL NOT alter results versus a back-to-back stream.
REQ-018 No backpressure; one sample accepted per valid cycle.

Reset
REQ-019 While rst=1 at a clock edge, signal_out SHALL become 0, signal_out_valid 0, all history entries 0 (no ISI subtracted).
REQ-020 rst SHALL take priority over signal_in_valid; a sample presented during reset SHALL be dropped.
REQ-021 First valid sample after reset SHALL pass through uncorrected (signal_out = signal_in).

Configuration
REQ-022 Macro DFE_SATURATE_EN SHALL select the output narrowing.
REQ-023 With DFE_SATURATE_EN defined, c SHALL clamp to [-2^(SR-1), 2^(SR-1)-1]; without it, c SHALL be truncated to its low SIGNAL_RESOLUTION bits (wrap-around). Slicing always uses the full-width c.

Verification
REQ-024 Reset: hold rst=1 two cycles with signal_in_valid=1, signal_in=100 -> signal_out=0, signal_out_valid=0, next valid input 100 -> output 100.
REQ-025 Channel stream: after reset, inputs 84, 14, 35 back-to-back -> outputs 84, -28, 28 on consecutive cycles, each valid one cycle after input.
REQ-026 Valid gaps: same stream as REQ-025 with 3 idle cycles between samples -> identical outputs; signal_out held and signal_out_valid=0 during gaps.
REQ-027 Saturation: after reset inputs 84, 126, -512 -> third corrected value -575; with DFE_SATURATE_EN output -512, without it output 449.
REQ-028 Slicer boundary: after reset inputs 0, 0 -> outputs 0, -14 (first decided +28); after reset inputs 56, 0 -> outputs 56, -42 (56 decides +84).
REQ-029 Reset mid-stream: inputs 84, 14 then rst=1 one cycle with valid input 35 -> 35 dropped, next input 35 -> output 35.
